// File: rtl/tx_frame_serializer.sv
// Serial frame transmitter: preamble, SFD, header, payload and CRC-8, MSB-first on one line.
// Build with TX_FAULT_INJECT_EN defined to add tx_fault (inverts the first data bit of a frame).
module tx_frame_serializer #(
    parameter int unsigned MAX_BYTES     = 16,
    parameter int unsigned LEN_BITS      = 4,
    parameter int unsigned PREAMBLE_BITS = 16,
    parameter int unsigned BIT_DIV       = 1,
    parameter int unsigned IFG_BITS      = 12,
    parameter logic [7:0]  CRC_POLY      = 8'h07,
    parameter logic [7:0]  CRC_INIT      = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [7:0]             tx_header,
    input  logic [MAX_BYTES*8-1:0] tx_payload,
`ifdef TX_FAULT_INJECT_EN
    input  logic                   tx_fault,
`endif
    output logic                   tx_line,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err
);

    localparam int unsigned PW        = MAX_BYTES * 8;
    localparam int unsigned NW        = LEN_BITS + 1;
    localparam logic [7:0]  SFD       = 8'hAB;
    localparam logic [15:0] BAUD_LAST = 16'(BIT_DIV - 1);
    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_HEADER,
        S_DATA,
        S_CRC,
        S_IFG
    } state_t;

    state_t          state;
    logic [15:0]     baud_cnt;
    logic [7:0]      bit_cnt;
    logic [8:0]      byte_cnt;
    logic [7:0]      hdr;
    logic [7:0]      osr;
    logic [PW-1:0]   shreg;
    logic [NW-1:0]   nbytes;
    logic [7:0]      crc;
    logic            data_bit;
`ifdef TX_FAULT_INJECT_EN
    logic            fault_q;
`endif

    logic [NW-1:0]   n_req;
    logic            len_bad;
    logic            bit_end;
    logic            last_bit;
    logic            crc_fb;
    logic [7:0]      crc_nx;

    // Request length decode, bit-period timing and the CRC step for the data bit on the line
    always_comb begin
        n_req    = NW'(tx_header[LEN_BITS-1:0]) + NW'(1);
        len_bad  = (32'(n_req) > MAX_BYTES);
        bit_end  = (baud_cnt == BAUD_LAST);
        crc_fb   = crc[7] ^ data_bit;
        crc_nx   = {crc[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
        last_bit = 1'b0;
        case (state)
            S_PREAMBLE: last_bit = (bit_cnt == PRE_LAST);
            S_SFD,
            S_HEADER,
            S_CRC:      last_bit = (bit_cnt == 8'd7);
            S_DATA:     last_bit = (bit_cnt == 8'd7) && (byte_cnt == 9'(nbytes) - 9'd1);
            S_IFG:      last_bit = (bit_cnt == IFG_LAST);
            default:    last_bit = 1'b0;
        endcase
    end

    // Frame sequencer; tx_line is loaded with the bit that the new state/counter value will carry
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 8'd0;
            byte_cnt <= 9'd0;
            hdr      <= 8'd0;
            osr      <= 8'd0;
            shreg    <= '0;
            nbytes   <= '0;
            crc      <= CRC_INIT;
            data_bit <= 1'b0;
`ifdef TX_FAULT_INJECT_EN
            fault_q  <= 1'b0;
`endif
            tx_line  <= 1'b0;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (state == S_IDLE) begin
                if (tx_start) begin
                    if (len_bad) begin
                        tx_err <= 1'b1;
                    end else begin
                        state    <= S_PREAMBLE;
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 8'd0;
                        byte_cnt <= 9'd0;
                        hdr      <= tx_header;
                        shreg    <= tx_payload;
                        nbytes   <= n_req;
                        crc      <= CRC_INIT;
`ifdef TX_FAULT_INJECT_EN
                        fault_q  <= tx_fault;
`endif
                        tx_line  <= 1'b1;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
            end else if (!bit_end) begin
                baud_cnt <= baud_cnt + 16'd1;
            end else begin
                baud_cnt <= 16'd0;
                if (state == S_DATA) begin
                    crc <= crc_nx;
                end
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + 8'd1;
                    case (state)
                        S_PREAMBLE: tx_line <= bit_cnt[0];
                        S_SFD,
                        S_HEADER,
                        S_CRC: begin
                            tx_line <= osr[7];
                            osr     <= {osr[6:0], 1'b0};
                        end
                        S_DATA: begin
                            tx_line  <= shreg[PW-1];
                            data_bit <= shreg[PW-1];
                            shreg    <= {shreg[PW-2:0], 1'b0};
                            if (bit_cnt == 8'd7) begin
                                bit_cnt  <= 8'd0;
                                byte_cnt <= byte_cnt + 9'd1;
                            end
                        end
                        default: tx_line <= 1'b0;
                    endcase
                end else begin
                    bit_cnt  <= 8'd0;
                    byte_cnt <= 9'd0;
                    case (state)
                        S_PREAMBLE: begin
                            state   <= S_SFD;
                            tx_line <= SFD[7];
                            osr     <= {SFD[6:0], 1'b0};
                        end
                        S_SFD: begin
                            state   <= S_HEADER;
                            tx_line <= hdr[7];
                            osr     <= {hdr[6:0], 1'b0};
                        end
                        S_HEADER: begin
                            state    <= S_DATA;
`ifdef TX_FAULT_INJECT_EN
                            tx_line  <= shreg[PW-1] ^ fault_q;
`else
                            tx_line  <= shreg[PW-1];
`endif
                            data_bit <= shreg[PW-1];
                            shreg    <= {shreg[PW-2:0], 1'b0};
                        end
                        S_DATA: begin
                            state   <= S_CRC;
                            tx_line <= crc_nx[7];
                            osr     <= {crc_nx[6:0], 1'b0};
                        end
                        S_CRC: begin
                            tx_done <= 1'b1;
                            tx_line <= 1'b0;
                            if (IFG_BITS != 0) begin
                                state <= S_IFG;
                            end else begin
                                state    <= S_IDLE;
                                tx_ready <= 1'b1;
                                tx_busy  <= 1'b0;
                            end
                        end
                        default: begin
                            state    <= S_IDLE;
                            tx_line  <= 1'b0;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: vector table, hand sequences and random frames vs a bit-list model.
module tb_tx_frame_serializer;

    localparam int unsigned A_MAX = 16, A_PRE = 16, A_DIV = 1, A_IFG = 12;
    localparam int unsigned B_MAX = 4,  B_PRE = 8,  B_DIV = 3, B_IFG = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start_a, start_b, fault_a, fault_b;
    logic [7:0]   hdr_a, hdr_b;
    logic [127:0] pay_a;
    logic [31:0]  pay_b;
    logic line_a, ready_a, busy_a, done_a, err_a;
    logic line_b, ready_b, busy_b, done_b, err_b;

    tx_frame_serializer #(.MAX_BYTES(A_MAX), .LEN_BITS(4), .PREAMBLE_BITS(A_PRE),
                          .BIT_DIV(A_DIV), .IFG_BITS(A_IFG)) dut_a (
        .clk(clk), .rst(rst), .tx_start(start_a), .tx_header(hdr_a), .tx_payload(pay_a),
`ifdef TX_FAULT_INJECT_EN
        .tx_fault(fault_a),
`endif
        .tx_line(line_a), .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx_err(err_a)
    );

    tx_frame_serializer #(.MAX_BYTES(B_MAX), .LEN_BITS(4), .PREAMBLE_BITS(B_PRE),
                          .BIT_DIV(B_DIV), .IFG_BITS(B_IFG)) dut_b (
        .clk(clk), .rst(rst), .tx_start(start_b), .tx_header(hdr_b), .tx_payload(pay_b),
`ifdef TX_FAULT_INJECT_EN
        .tx_fault(fault_b),
`endif
        .tx_line(line_b), .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .tx_err(err_b)
    );

    int checks = 0;
    int errors = 0;
    bit exp_bits [256];
    bit obs_bits [256];
    int nbits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pre_of(input int u); return (u == 0) ? A_PRE : B_PRE; endfunction
    function automatic int div_of(input int u); return (u == 0) ? A_DIV : B_DIV; endfunction
    function automatic int ifg_of(input int u); return (u == 0) ? A_IFG : B_IFG; endfunction
    function automatic int max_of(input int u); return (u == 0) ? A_MAX : B_MAX; endfunction

    // {line, ready, busy, done, err}
    function automatic logic [4:0] outs(input int u);
        return (u == 0) ? {line_a, ready_a, busy_a, done_a, err_a}
                        : {line_b, ready_b, busy_b, done_b, err_b};
    endfunction

    task automatic drive(input int u, input logic s, input logic [7:0] h,
                         input logic [127:0] p, input logic f);
        if (u == 0) begin
            start_a = s; hdr_a = h; pay_a = p; fault_a = f;
        end else begin
            start_b = s; hdr_b = h; pay_b = p[127:96]; fault_b = f;
        end
    endtask

    task automatic set_start(input int u, input logic s);
        if (u == 0) start_a = s; else start_b = s;
    endtask

    // CRC-8, poly 0x07, seed 0, over the first n bytes of a top-aligned payload
    function automatic logic [7:0] crc_ref(input logic [127:0] p, input int n);
        logic [7:0] c;
        logic [7:0] by;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            by = p[127-8*i -: 8];
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ by[j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic push(input bit b);
        exp_bits[nbits] = b;
        nbits++;
    endtask

    // Expected line bits of one frame, one entry per bit period
    task automatic build(input int u, input logic [7:0] h, input logic [127:0] p, input logic f);
        int n;
        logic [7:0] sfd;
        logic [7:0] by;
        logic [7:0] c;
        n = int'(h[3:0]) + 1;
        sfd = 8'hAB;
        c = crc_ref(p, n);
        nbits = 0;
        for (int i = 0; i < pre_of(u); i++) push((i % 2) == 0);
        for (int j = 7; j >= 0; j--) push(sfd[j]);
        for (int j = 7; j >= 0; j--) push(h[j]);
        for (int i = 0; i < n; i++) begin
            by = p[127-8*i -: 8];
            for (int j = 7; j >= 0; j--) push(by[j] ^ (f && i == 0 && j == 7));
        end
        for (int j = 7; j >= 0; j--) push(c[j]);
    endtask

    // mode 0: plain, 1: start pulses during DATA, 2: start on the return-to-IDLE edge,
    // 3: reset in the 10th data bit
    task automatic run_frame(input int u, input logic [7:0] h, input logic [127:0] p,
                             input logic f, input int mode,
                             output logic [7:0] crc_obs, output logic [7:0] d0_obs);
        int n, d, fl, total, dstart, dend;
        logic [4:0] o;
        crc_obs = 8'h00;
        d0_obs  = 8'h00;
        n = int'(h[3:0]) + 1;
        d = div_of(u);
        @(negedge clk);
        o = outs(u);
        chk("ready_before_start", 32'(o[3]), 32'd1);
        drive(u, 1'b1, h, p, f);
        @(posedge clk);
        @(negedge clk);
        drive(u, 1'b0, 8'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        if (n > max_of(u)) begin
            o = outs(u);
            chk("reject_err_pulse", 32'(o[0]), 32'd1);
            chk("reject_line_idle", 32'(o[4]), 32'd0);
            chk("reject_busy_low", 32'(o[2]), 32'd0);
            chk("reject_ready_high", 32'(o[3]), 32'd1);
            @(negedge clk);
            o = outs(u);
            chk("reject_err_one_cycle", 32'(o[0]), 32'd0);
            chk("reject_still_idle", 32'({o[4], o[2]}), 32'd0);
            return;
        end
        build(u, h, p, f);
        fl     = nbits;
        total  = (fl + ifg_of(u)) * d;
        dstart = (pre_of(u) + 16) * d;
        dend   = (pre_of(u) + 16 + 8 * n) * d;
        for (int c = 0; c <= total + 1; c++) begin
            if (c > 0) @(negedge clk);
            o = outs(u);
            chk("line", 32'(o[4]), (c < fl * d) ? 32'(exp_bits[c / d]) : 32'd0);
            chk("busy", 32'(o[2]), 32'(c < total));
            chk("ready", 32'(o[3]), 32'(c >= total));
            chk("done", 32'(o[1]), 32'(c == fl * d));
            chk("err_quiet", 32'(o[0]), 32'd0);
            if (c < fl * d && (c % d) == 0) obs_bits[c / d] = o[4];
            if (mode == 1) set_start(u, (c >= dstart && c < dend && (c % 2) == 1));
            if (mode == 2) set_start(u, c == total - 1);
            if (mode == 3 && c == dstart + 9 * d) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                o = outs(u);
                chk("abort_line_low", 32'(o[4]), 32'd0);
                chk("abort_ready_high", 32'(o[3]), 32'd1);
                chk("abort_busy_low", 32'(o[2]), 32'd0);
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    o = outs(u);
                    chk("abort_no_done", 32'({o[1], o[4]}), 32'd0);
                end
                return;
            end
        end
        for (int j = 0; j < 8; j++) begin
            crc_obs[7-j] = obs_bits[fl - 8 + j];
            d0_obs[7-j]  = obs_bits[pre_of(u) + 16 + j];
        end
    endtask

    typedef struct {
        int         u;
        logic [7:0] hdr;
        logic [31:0] head;
        int         mode;
        logic [7:0] crc;
        logic       crc_known;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   crc_o, d0_o;
        logic [127:0] p;
        logic [7:0]   h;
        int           u;

        tbl[0] = '{0, 8'h00, 32'hFF000000, 0, 8'hF3, 1'b1};
        tbl[1] = '{1, 8'h00, 32'h01000000, 0, 8'h07, 1'b1};
        tbl[2] = '{1, 8'h07, 32'h12345678, 0, 8'h00, 1'b0};
        tbl[3] = '{1, 8'h03, 32'hAA55F00F, 0, 8'h00, 1'b0};
        tbl[4] = '{1, 8'h04, 32'hDEADBEEF, 0, 8'h00, 1'b0};
        tbl[5] = '{0, 8'hF0, 32'h80000000, 0, 8'h00, 1'b0};
        tbl[6] = '{0, 8'h0F, 32'hC3A5_0F96, 2, 8'h00, 1'b0};

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, '0, 1'b0);
        drive(1, 1'b0, 8'h00, '0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state_a", 32'(outs(0)), 32'b01000);
        chk("reset_state_b", 32'(outs(1)), 32'b01000);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_a", 32'(outs(0)), 32'b01000);

        for (int i = 0; i < 7; i++) begin
            p = {tbl[i].head, $urandom, $urandom, $urandom};
            run_frame(tbl[i].u, tbl[i].hdr, p, 1'b0, tbl[i].mode, crc_o, d0_o);
            if (tbl[i].crc_known) chk("vector_crc", 32'(crc_o), 32'(tbl[i].crc));
        end

        p = {72'h31_32_33_34_35_36_37_38_39, 56'h0};
        run_frame(0, 8'h08, p, 1'b0, 1, crc_o, d0_o);
        chk("check_string_crc", 32'(crc_o), 32'hF4);

        run_frame(0, 8'h08, p, 1'b0, 3, crc_o, d0_o);
        run_frame(0, 8'h08, p, 1'b0, 0, crc_o, d0_o);
        chk("after_abort_crc", 32'(crc_o), 32'hF4);

`ifdef TX_FAULT_INJECT_EN
        run_frame(0, 8'h00, {8'hFF, 120'h0}, 1'b1, 0, crc_o, d0_o);
        chk("fault_data_byte", 32'(d0_o), 32'h7F);
        chk("fault_crc_unchanged", 32'(crc_o), 32'hF3);
        run_frame(0, 8'h00, {8'hFF, 120'h0}, 1'b0, 0, crc_o, d0_o);
        chk("fault_not_sticky", 32'(d0_o), 32'hFF);
`endif

        for (int i = 0; i < 8; i++) begin
            u = int'($urandom_range(0, 1));
            h = 8'($urandom);
            p = {$urandom, $urandom, $urandom, $urandom};
            run_frame(u, h, p, 1'b0, 0, crc_o, d0_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
